// File: rtl/uart_pkg.sv
// Shared UART definitions: default word/FIFO sizes, FIFO operation encoding
// and the pointer-width helper used by the TX/RX FIFOs.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b10,
    FIFO_POP  = 2'b01,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo_param_if.sv
// Push/pop handshake bundle between a UART FIFO (slave) and its user (master).
interface uart_fifo_param_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_W
) ();

  logic                  write_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;

  modport master (
    output write_en, write_data, read_en,
    input  read_data, read_valid
  );

  modport slave (
    input  write_en, write_data, read_en,
    output read_data, read_valid
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_W,
  parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised UART FIFO with level, thresholds, sticky error flags and flush.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module uart_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_W,
  parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
  parameter int unsigned AFULL_TH   = DEPTH - 2,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     err_clear,
  uart_fifo_param_if.slave         bus,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] head;
  logic                  rd_acc, wr_acc, ovf_evt, udf_evt;
  fifo_op_e              op;

  assign empty        = (level == '0);
  assign full         = (32'(level) == DEPTH);
  assign almost_full  = (32'(level) >= AFULL_TH);
  assign almost_empty = (32'(level) <= AEMPTY_TH);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign rd_acc  = bus.read_en && !empty;
  assign wr_acc  = bus.write_en && (!full || rd_acc);
  assign ovf_evt = bus.write_en && !wr_acc && !flush;
  assign udf_evt = bus.read_en && empty && !flush;

  always_comb begin
    op = FIFO_IDLE;
    case ({wr_acc, rd_acc})
      2'b10:   op = FIFO_PUSH;
      2'b01:   op = FIFO_POP;
      2'b11:   op = FIFO_BOTH;
      default: op = FIFO_IDLE;
    endcase
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !flush && reset),
    .waddr (wr_ptr),
    .wdata (bus.write_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case (op)
        FIFO_PUSH: level <= level + LW'(1);
        FIFO_POP:  level <= level - LW'(1);
        default:   ;
      endcase
    end
  end

  // Error event in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)        overflow <= 1'b1;
      else if (err_clear) overflow <= 1'b0;
      if (udf_evt)        underflow <= 1'b1;
      else if (err_clear) underflow <= 1'b0;
    end
  end

`ifdef UART_FIFO_FWFT_EN
  assign bus.read_data  = head;
  assign bus.read_valid = !empty;
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.read_data  <= '0;
      bus.read_valid <= 1'b0;
    end else if (flush) begin
      bus.read_valid <= 1'b0;
    end else begin
      bus.read_valid <= rd_acc;
      if (rd_acc) bus.read_data <= head;
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_param.sv
// Scoreboard bench for uart_fifo_param (DEPTH 16, DATA_WIDTH 8), both read modes.
module tb_uart_fifo_param;

  logic       clk = 1'b0;
  logic       reset, flush, err_clear;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] level;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];

  uart_fifo_param_if #(.DATA_WIDTH(8)) bus ();

  uart_fifo_param #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .AFULL_TH   (14),
    .AEMPTY_TH  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .err_clear    (err_clear),
    .bus          (bus),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: every word the FIFO presents is compared against the scoreboard queue.
  always @(negedge clk) begin
    logic [7:0] e;
`ifdef UART_FIFO_FWFT_EN
    if (reset && bus.read_en && bus.read_valid) begin
`else
    if (reset && bus.read_valid) begin
`endif
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL pop_unexpected: got 0x%02h, required no word", bus.read_data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", int'(bus.read_data), int'(e));
      end
    end
  end

  task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                     input logic ex, input logic [7:0] ev);
    bus.write_en   = we;
    bus.write_data = wd;
    bus.read_en    = re;
    if (ex) exp_q.push_back(ev);
    @(posedge clk); #1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; err_clear = 1'b0;
    bus.write_en = 1'b0; bus.write_data = '0; bus.read_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
    chk("rst_rvalid", int'(bus.read_valid), 0);
`ifndef UART_FIFO_FWFT_EN
    chk("rst_rdata", int'(bus.read_data), 0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill 0x00..0x0F, watching the thresholds move with level
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
      chk("fill_afull", int'(almost_full), (i + 1 >= 14) ? 1 : 0);
      chk("fill_aempty", int'(almost_empty), (i + 1 <= 2) ? 1 : 0);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);

    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
    chk("drain_empty", int'(empty), 1);
    chk("drain_level", int'(level), 0);

    // Full with simultaneous push/pop
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 8'hAA, 1'b1, 1'b1, 8'h20);
    chk("both_level", int'(level), 16);
    chk("both_ovf", int'(overflow), 0);

    // Full, push alone is rejected
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
    chk("ovf_level", int'(level), 16);
    chk("ovf_set", int'(overflow), 1);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk("ovf_clear", int'(overflow), 0);

    for (int i = 1; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h20 + i));
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'hAA);
    chk("wrap_empty", int'(empty), 1);

    // Empty, pop with simultaneous push
    cyc(1'b1, 8'h3C, 1'b1, 1'b0, 8'h00);
    chk("udf_set", int'(underflow), 1);
    chk("udf_level", int'(level), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h3C);
    chk("udf_pop_level", int'(level), 0);

    // Flush at level 5; the push in the flush cycle is dropped
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
    chk("pre_flush_level", int'(level), 5);
    flush = 1'b1;
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 8'h00);
    flush = 1'b0;
    chk("flush_level", int'(level), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_udf_kept", int'(underflow), 1);
    chk("flush_rvalid", int'(bus.read_valid), 0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    chk("post_flush_empty", int'(empty), 1);

    // err_clear loses to a same-cycle underflow event, then clears
    err_clear = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("udf_wins", int'(underflow), 1);
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk("udf_clear", int'(underflow), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("idle_rvalid", int'(bus.read_valid), 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
